// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, samples the combinational instruction
// memory and buffers {pc, inst} pairs in a small FIFO toward decode.
module inst_fetch #(
    parameter int             WORD      = 64,
    parameter int             INST_SIZE = 32,
    parameter int             DEPTH     = 2,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD-1:0]      imem_pc,
    input  logic [INST_SIZE-1:0] imem_inst,
    input  logic                 br_taken,
    input  logic [WORD-1:0]      br_target,
    input  logic                 halt,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [INST_SIZE-1:0] if_inst,
    output logic [WORD-1:0]      if_pc,
    output logic [31:0]          fetch_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INST_SIZE-1:0] inst;
    } fetch_ent_t;

    fetch_ent_t        fifo [DEPTH];
    fetch_ent_t        head;
    logic [WORD-1:0]   pc_q;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_d;
    logic              push, pop, full;

    assign imem_pc  = pc_q;
    assign if_valid = (count != '0);
    assign head     = fifo[rd_ptr];
    assign if_inst  = if_valid ? head.inst : '0;
    assign if_pc    = if_valid ? head.pc   : '0;

    // A pop in the same cycle frees the head slot, so a full FIFO still accepts a push.
    assign pop  = if_valid && if_ready;
    assign full = (count == CW'(DEPTH)) && !pop;
    assign push = !rst && !br_taken && !halt && !full;

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_cnt <= '0;
        end else if (br_taken) begin
            // Redirect wins over halt; any same-cycle pop is simply discarded with the flush.
            pc_q   <= {br_target[WORD-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q      <= pc_q + WORD'(4);
                wr_ptr    <= wr_ptr + AW'(1);
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{pc: pc_q, inst: imem_inst};
    end
endmodule
